// File: rtl/res_dump.sv
// res_dump: result-RAM readback engine. After a start pulse it reads
// result bytes 0..N_PIX-1 through the RAM read port and streams them out.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           one-cycle pulse that begins a dump (ignored when busy)
//   busy            dump in progress (READ, DRAIN, FIN)
//   dump_done       one-cycle pulse after the last byte is accepted
//   res_rd/res_addr result-RAM read request (registered)
//   res_di          result-RAM read data, valid one cycle after res_rd
//   out_valid/out_ready/out_data/out_addr  {addr,data} output stream
//   chksum          running byte sum, present only with RES_DUMP_CHKSUM_EN
//
// Optional feature macro: RES_DUMP_CHKSUM_EN
module res_dump #(
    parameter int N_PIX  = 16384,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              dump_done,
    output logic              res_rd,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [7:0]        res_di,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr
`ifdef RES_DUMP_CHKSUM_EN
    ,
    output logic [23:0]       chksum
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N_PIX - 1);

    logic [1:0]        state;
    logic [ADDR_W:0]   iss_cnt;

    logic [ADDR_W-1:0] f_addr [2];
    logic [7:0]        f_data [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        f_cnt;

    logic              push;
    logic              pop;
    logic              issue;
    logic [1:0]        occ_next;

    // A read issued last cycle returns on this edge, so it is the push.
    assign push      = res_rd;
    assign pop       = out_valid && out_ready;
    assign out_valid = (f_cnt != 2'd0);
    assign out_data  = f_data[rd_ptr];
    assign out_addr  = f_addr[rd_ptr];
    assign busy      = (state != S_IDLE);
    assign dump_done = (state == S_FIN);

    // Occupancy after this edge; a new read may only be issued if its
    // return next edge still has a free slot, so the FIFO never overflows.
    assign occ_next = f_cnt + {1'b0, push} - {1'b0, pop};
    assign issue    = (state == S_READ) && (occ_next < 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            iss_cnt  <= '0;
            res_rd   <= 1'b0;
            res_addr <= '0;
        end else begin
            res_rd <= issue;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_READ;
                        iss_cnt <= '0;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        res_addr <= iss_cnt[ADDR_W-1:0];
                        iss_cnt  <= iss_cnt + 1'b1;
                        if (iss_cnt == LAST)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (f_cnt == 2'd0 && !res_rd)
                        state <= S_FIN;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-entry {addr,data} FIFO; res_addr still holds the address of the
    // returning read on the capture edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            f_cnt  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                f_addr[i] <= '0;
                f_data[i] <= '0;
            end
        end else begin
            if (push) begin
                f_addr[wr_ptr] <= res_addr;
                f_data[wr_ptr] <= res_di;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            f_cnt <= occ_next;
        end
    end

`ifdef RES_DUMP_CHKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            chksum <= '0;
        else if (state == S_IDLE && start)
            chksum <= '0;
        else if (pop)
            chksum <= chksum + {16'd0, out_data};
    end
`endif

endmodule

// File: tb/tb_res_dump.sv
// tb_res_dump: scoreboard bench for res_dump, a full-size instance and
// an N_PIX=1 instance sharing clock and reset.
module tb_res_dump;

    localparam int NB = 16384;
    localparam int AW = 14;
    localparam int LIM = 40000;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          b_start = 1'b0;
    logic          b_busy, b_done, b_rd, b_valid;
    logic          b_ready = 1'b0;
    logic [AW-1:0] b_raddr, b_oaddr;
    logic [7:0]    b_di = 8'd0;
    logic [7:0]    b_data;

    logic          o_start = 1'b0;
    logic          o_busy, o_done, o_rd, o_valid;
    logic          o_ready = 1'b0;
    logic [AW-1:0] o_raddr, o_oaddr;
    logic [7:0]    o_di = 8'd0;
    logic [7:0]    o_data;
`ifdef RES_DUMP_CHKSUM_EN
    logic [23:0]   b_sum, o_sum;
`endif

    res_dump #(.N_PIX(NB), .ADDR_W(AW)) u_big (
        .clk(clk), .reset(reset), .start(b_start),
        .busy(b_busy), .dump_done(b_done),
        .res_rd(b_rd), .res_addr(b_raddr), .res_di(b_di),
        .out_valid(b_valid), .out_ready(b_ready),
        .out_data(b_data), .out_addr(b_oaddr)
`ifdef RES_DUMP_CHKSUM_EN
        , .chksum(b_sum)
`endif
    );

    res_dump #(.N_PIX(1), .ADDR_W(AW)) u_one (
        .clk(clk), .reset(reset), .start(o_start),
        .busy(o_busy), .dump_done(o_done),
        .res_rd(o_rd), .res_addr(o_raddr), .res_di(o_di),
        .out_valid(o_valid), .out_ready(o_ready),
        .out_data(o_data), .out_addr(o_oaddr)
`ifdef RES_DUMP_CHKSUM_EN
        , .chksum(o_sum)
`endif
    );

    // RAM models: data updates on the negedge that samples res_rd=1.
    logic [7:0] ram_b [NB];
    logic [7:0] ram_o = 8'h5A;
    always @(negedge clk) if (b_rd) b_di <= ram_b[b_raddr];
    always @(negedge clk) if (o_rd) o_di <= (o_raddr == '0) ? ram_o : 8'hEE;

    ent_t sb_b[$];
    ent_t sb_o[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    // Monitor, full-size instance.
    int rdn_b = 0, xfer_b = 0, done_b = 0, done_cyc_b = 0;
    always @(negedge clk) begin
        if (!reset) begin
            rdn_b = 0;
            xfer_b = 0;
        end else begin
            if (b_rd) rdn_b++;
            if (b_valid && b_ready) begin
                xfer_b++;
                checks++;
                if (sb_b.size() == 0) begin
                    errors++;
                    $display("FAIL big_extra got a=%0d d=%0h want none",
                             b_oaddr, b_data);
                end else begin
                    ent_t e;
                    e = sb_b.pop_front();
                    if (b_oaddr !== e.a || b_data !== e.d) begin
                        errors++;
                        $display("FAIL big_xfer got a=%0d d=%0h want a=%0d d=%0h",
                                 b_oaddr, b_data, e.a, e.d);
                    end
                end
            end
            if (b_busy) begin
                checks++;
                if (rdn_b - xfer_b > 2) begin
                    errors++;
                    $display("FAIL big_occ got %0d want <=2", rdn_b - xfer_b);
                end
            end
        end
        if (b_done) begin
            done_b++;
            done_cyc_b = cyc;
        end
    end

    // Monitor, single-pixel instance.
    int rdn_o = 0, xfer_o = 0, done_o = 0;
    int done_cyc_o = 0, rd_cyc_o = 0, v_cyc_o = 0;
    logic pv_o = 1'b0;
    always @(negedge clk) begin
        if (o_rd) begin
            rdn_o++;
            rd_cyc_o = cyc;
        end
        if (o_valid && !pv_o) v_cyc_o = cyc;
        pv_o = o_valid;
        if (o_done) begin
            done_o++;
            done_cyc_o = cyc;
        end
        if (o_valid && o_ready) begin
            xfer_o++;
            checks++;
            if (sb_o.size() == 0) begin
                errors++;
                $display("FAIL one_extra got a=%0d d=%0h want none",
                         o_oaddr, o_data);
            end else begin
                ent_t e;
                e = sb_o.pop_front();
                if (o_oaddr !== e.a || o_data !== e.d) begin
                    errors++;
                    $display("FAIL one_xfer got a=%0d d=%0h want a=%0d d=%0h",
                             o_oaddr, o_data, e.a, e.d);
                end
            end
        end
    end

    // Random out_ready driver for the full-size instance.
    logic rnd_en = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_en) b_ready = 1'($urandom_range(0, 1));
    end

    function automatic int img_sum();
        int s = 0;
        for (int i = 0; i < NB; i++) s += int'(ram_b[i]);
        return s;
    endfunction

    task automatic start_big(output int s);
        ent_t e;
        for (int i = 0; i < NB; i++) begin
            e.a = AW'(i);
            e.d = ram_b[i];
            sb_b.push_back(e);
        end
        @(posedge clk);
        #1 b_start = 1'b1;
        s = cyc + 1;
        @(posedge clk);
        #1 b_start = 1'b0;
    endtask

    task automatic pulse_big_start();
        @(posedge clk);
        #1 b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
    endtask

    task automatic wait_big_done(input int n0);
        for (int k = 0; k < LIM; k++) begin
            if (done_b != n0) break;
            @(posedge clk);
        end
        #1;
        checks++;
        if (done_b == n0) begin
            errors++;
            $display("FAIL big_done_timeout got %0d want %0d", done_b, n0 + 1);
        end
    endtask

    task automatic wait_xfer(input int n);
        for (int k = 0; k < LIM; k++) begin
            if (xfer_b >= n) break;
            @(posedge clk);
        end
        checks++;
        if (xfer_b < n) begin
            errors++;
            $display("FAIL big_xfer_timeout got %0d want %0d", xfer_b, n);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(b_busy), 0);
        chk({tag, "_done"}, 32'(b_done), 0);
        chk({tag, "_rd"}, 32'(b_rd), 0);
        chk({tag, "_raddr"}, 32'(b_raddr), 0);
        chk({tag, "_valid"}, 32'(b_valid), 0);
        chk({tag, "_data"}, 32'(b_data), 0);
        chk({tag, "_oaddr"}, 32'(b_oaddr), 0);
`ifdef RES_DUMP_CHKSUM_EN
        chk({tag, "_sum"}, 32'(b_sum), 0);
`endif
    endtask

    initial begin
        int s, n0, ha, hd, esum;
        for (int i = 0; i < NB; i++) ram_b[i] = 8'(i);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        chk("rst_one_busy", 32'(o_busy), 0);
        chk("rst_one_valid", 32'(o_valid), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single pixel dump
        begin
            ent_t e;
            e.a = '0;
            e.d = 8'h5A;
            sb_o.push_back(e);
        end
        o_ready = 1'b1;
        n0 = done_o;
        @(posedge clk);
        #1 o_start = 1'b1;
        s = cyc + 1;
        @(posedge clk);
        #1 o_start = 1'b0;
        for (int k = 0; k < 20 && done_o == n0; k++) @(posedge clk);
        #1;
        chk("one_done_cnt", 32'(done_o), 32'(n0 + 1));
        chk("one_done_lat", 32'(done_cyc_o - s), 4);
        chk("one_rd_cycles", 32'(rdn_o), 1);
        chk("one_rd_lat", 32'(rd_cyc_o - s), 1);
        chk("one_valid_lat", 32'(v_cyc_o - s), 2);
        chk("one_xfers", 32'(xfer_o), 1);
        chk("one_sb_left", 32'(sb_o.size()), 0);
`ifdef RES_DUMP_CHKSUM_EN
        chk("one_sum", 32'(o_sum), 32'h5A);
`endif

        // Full dump, ramp image, out_ready held high
        b_ready = 1'b1;
        esum = img_sum();
        n0 = done_b;
        start_big(s);
        chk("t1_busy", 32'(b_busy), 1);
        wait_big_done(n0);
        chk("t1_done_lat", 32'(done_cyc_b - s), 32'(NB + 3));
        chk("t1_sb_left", 32'(sb_b.size()), 0);
        chk("t1_sum_model", 32'(esum), 32'h1FE000);
`ifdef RES_DUMP_CHKSUM_EN
        chk("t1_sum", 32'(b_sum), 32'(esum));
`endif
        @(posedge clk);
        #1 chk("t1_idle", 32'(b_busy), 0);

        // Random image, random out_ready, stall and extra start pulses
        for (int i = 0; i < NB; i++) ram_b[i] = 8'($urandom);
        esum = img_sum();
        n0 = done_b;
        rnd_en = 1'b1;
        start_big(s);
        wait_xfer(50);
        @(posedge clk);
        #2;
        rnd_en = 1'b0;
        b_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ha = int'(b_oaddr);
        hd = int'(b_data);
        for (int k = 0; k < 8; k++) begin
            chk("stall_rd", 32'(b_rd), 0);
            chk("stall_valid", 32'(b_valid), 1);
            chk("stall_addr", 32'(b_oaddr), 32'(ha));
            chk("stall_data", 32'(b_data), 32'(hd));
            @(posedge clk);
            #1;
        end
        rnd_en = 1'b1;
        wait_xfer(1000);
        pulse_big_start();
        wait_xfer(5000);
        pulse_big_start();
        wait_big_done(n0);
        repeat (5) @(posedge clk);
        #1;
        chk("t2_one_done", 32'(done_b), 32'(n0 + 1));
        chk("t2_sb_left", 32'(sb_b.size()), 0);
`ifdef RES_DUMP_CHKSUM_EN
        chk("t2_sum", 32'(b_sum), 32'(esum));
`endif
        rnd_en = 1'b0;
        #2 b_ready = 1'b1;

        // Reset at transfer 100
        for (int i = 0; i < NB; i++) ram_b[i] = 8'(i);
        n0 = done_b;
        start_big(s);
        wait_xfer(100);
        @(posedge clk);
        #1 reset = 1'b0;
        sb_b.delete();
        #1 chk_reset_vals("abort");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_b), 32'(n0));
        chk("abort_idle", 32'(b_busy), 0);

        // Fresh start on an all-zero image
        for (int i = 0; i < NB; i++) ram_b[i] = 8'd0;
        n0 = done_b;
        start_big(s);
        wait_big_done(n0);
        chk("t4_done_lat", 32'(done_cyc_b - s), 32'(NB + 3));
        chk("t4_sb_left", 32'(sb_b.size()), 0);
`ifdef RES_DUMP_CHKSUM_EN
        chk("t4_sum", 32'(b_sum), 0);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got cycle %0d want completion", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/res_dump.md
# res_dump

Result-memory readback engine for the distance-transform subsystem. Once DT has asserted `done`, a `start` pulse makes the block scan the result RAM sequentially through the RAM's own read port. It uses the same `res_rd`/`res_addr`/`res_di` protocol that DT uses to write, so it is the reading end of that interface. Each byte is forwarded on a valid/ready stream tagged with its pixel address, for host upload or an on-chip checker.

## Interface
Parameters:
- `N_PIX`, 16384: number of result bytes to read; legal range 1..16384.
- `ADDR_W`, 14: width of the result-RAM address.

Ports:
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a dump. Ignored while `busy`=1.
- `busy` output 1: high from the cycle after an accepted `start` until `dump_done`.
- `dump_done` output 1: one-cycle pulse after the last byte has been accepted downstream.
- `res_rd` output 1: result-RAM read enable.
- `res_addr` output ADDR_W: result-RAM address.
- `res_di` input 8: result-RAM read data. The RAM updates it at the negedge on which it samples `res_rd`=1.
- `out_valid` output 1: stream data valid.
- `out_ready` input 1: downstream accepts data.
- `out_data` output 8: result byte.
- `out_addr` output ADDR_W: pixel index of `out_data`.
- `chksum` output 24: running byte sum. Exists only with `RES_DUMP_CHKSUM_EN`.

## Operation
State machine states:
- IDLE: waits for `start`.
- READ: issues addresses 0..N_PIX-1.
- DRAIN: the last address has been issued and the FIFO is not yet empty.
- FIN: one cycle; pulses `dump_done` and returns to IDLE.

Transitions:
- IDLE→READ on `start`. The issue counter clears to 0 on the same edge.
- READ→DRAIN on the edge that issues address N_PIX-1.
- DRAIN→FIN when the FIFO is empty, no read is in flight, and no handshake is pending.
- FIN→IDLE unconditionally.

Datapath:
- A 2-entry output FIFO holds {addr, data}. `out_valid` = FIFO not empty; the head entry drives `out_data`/`out_addr`.
- Issue rule: `res_rd`=1 in a cycle only if in READ and (FIFO occupancy + in-flight reads − pop this cycle) < 2. The FIFO therefore never overflows, and `res_rd` never stalls mid-read.
- Each issued address increments the issue counter by 1. The counter does not wrap; READ ends at N_PIX-1.
- `res_addr` holds its last value when `res_rd`=0. This must not cause RAM writes, because the block never drives `res_wr`.
- Handshake: a transfer occurs when `out_valid` && `out_ready`. `out_data`/`out_addr` stay stable while `out_valid`=1 and `out_ready`=0.
- A simultaneous push (read return) and pop with occupancy 1 or 2 is legal; occupancy stays unchanged.
- Reset mid-dump: the block aborts immediately. All state clears, with no `dump_done`. RAM contents are unaffected.

Output reset values: `busy`=0, `dump_done`=0, `res_rd`=0, `res_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `chksum`=0.

## Timing
- `res_rd` and `res_addr` are registered and change after posedge k.
- The RAM samples them at negedge k.
- `res_di` is captured into the FIFO at posedge k+1, a 1-cycle read latency.
- A captured byte is visible on `out_valid` after posedge k+1.
- `start` accepted at posedge s gives the first `res_rd`=1 in cycle s+1. The first `out_valid`=1 follows at s+2.
- Throughput is 1 byte/cycle with `out_ready` held at 1.
- A full dump with `out_ready`=1 takes N_PIX+3 cycles from `start` to `dump_done`.
- `dump_done` rises one cycle after the final handshake.
- `start` arriving in the same cycle as FIN is ignored.

## Configuration
- `RES_DUMP_CHKSUM_EN` defined:
  - `chksum` is a 24-bit register.
  - It clears on accepted `start`.
  - It adds zero-extended `out_data` on every handshake, with no wrap for N_PIX ≤ 16384.
  - It is final and stable from `dump_done` until the next `start`.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- N_PIX=16384, RAM[i]=i[7:0], `out_ready`=1 → 16384 transfers with `out_addr`=i and `out_data`=i[7:0]. `dump_done` comes 16387 cycles after `start`. `chksum`=0x1FE000.
- Random `out_ready` (50%), same image → identical ordered stream with no drops or duplicates; FIFO occupancy never exceeds 2. Holding `out_ready`=0 for 10 cycles → `res_rd` deasserts within 2 cycles and the output stays stable.
- N_PIX=1, RAM[0]=0x5A → exactly one transfer {0, 0x5A}, `res_rd` high for one cycle, `dump_done` 4 cycles after `start`.
- `start` pulsed again while `busy`=1 → ignored. The address sequence continues unchanged and only one `dump_done` occurs.
- `reset` asserted at transfer 100 → all outputs are at their reset values immediately and no `dump_done` appears. A fresh `start` restarts from address 0.
- All-zero image → `out_data`=0 throughout and `chksum`=0.
